data_mem: RTL and testbench
===========================

# data_mem

Word-addressed 16-bit data memory for the MIPS datapath's MEM stage. It accepts the ALU-computed address and the store data from the register file, and returns load data to the write-back mux. Reads are combinational and writes are synchronous on the rising clock edge. Synchronous reset restores the defined initial contents.

## Interface
- DEPTH, 256: number of 16-bit words; power of two, 2..65536.
- INIT_WORD0, 16'd5: reset value of word 0. All other words reset to 0.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- memRead  input  1  load strobe; see Configuration for its effect on read_data.
- memWrite  input  1  store strobe; sampled on the rising clk edge.
- address  input  16  word address; the low log2(DEPTH) bits select the word.
- write_data  input  16  store data.
- read_data  output  16  load data (combinational).

One clock; reset is synchronous and active-high.

## Operation
- Storage is DEPTH registers of 16 bits, with index = address[log2(DEPTH)-1:0].
- An address is in range when every bit of address above log2(DEPTH) is zero.
- Read:
  - read_data = mem[index] when the address is in range, else 16'h0000.
  - Purely combinational, with no clock dependency.
- Write: at a rising clk edge with rst=0, memWrite=1 and the address in range, mem[index] <= write_data.
- Out-of-range write: ignored, and no memory word changes.
- Reset: at a rising clk edge with rst=1:
  - word 0 <= INIT_WORD0;
  - all other words <= 0;
  - memWrite in the same cycle is ignored, because reset has priority.
- Simultaneous memRead=1 and memWrite=1 to the same address:
  - before the edge, read_data shows the old value;
  - after the edge, read_data shows the new value, with no bypass.
- There is no handshake and no busy state. Every cycle accepts one write.
- There are no X outputs after the first reset. Before the first reset, contents are undefined.

## Timing
- Read latency: 0 cycles, combinational from address, memRead and stored contents.
- Write latency: 1 edge. The new data is visible on read_data immediately after the rising edge that performs the write.
- Reset takes effect at the first rising edge with rst=1. read_data reflects the reset contents right after that edge:
  - read_data = INIT_WORD0 (5) when address = 0;
  - read_data = 0 for any other in-range address.
- Back-to-back writes to the same address on consecutive edges: the last write wins.
- Asserting reset mid-sequence discards all prior writes at that edge.

## Configuration
- DATA_MEM_READ_GATE_EN:
  - When defined, read_data = 16'h0000 whenever memRead=0. Otherwise read_data follows the Operation rules.
  - When undefined (default), memRead is ignored and read_data always follows the Operation rules. For example, address 0 after reset reads 5 even with memRead=0.

## Test plan
- Reset, then initial contents: pulse rst for 1 cycle; address=0, memRead=0 (macro undefined) -> read_data=5; address=1 -> read_data=0.
- Store then load:
  - address=20, write_data=15, memWrite=1, memRead=0 for one edge;
  - then memWrite=0, memRead=1 -> read_data=15;
  - address=21 -> read_data=0.
- Write without strobe: address=30, write_data=16'hBEEF, memWrite=0 for several edges -> read_data at address 30 stays 0.
- Out of range:
  - address=16'h0114, write_data=7, memWrite=1 -> read_data=0 at 16'h0114;
  - word 20 remains unchanged (15 from the previous scenario), since no word was written.
- Reset priority and reset mid-operation:
  - rst=1 and memWrite=1, address=0, write_data=9 on the same edge -> word 0 reads 5;
  - word 20 reads 0 after the reset.
- Gating (DATA_MEM_READ_GATE_EN defined): after reset, address=0 with memRead=0 -> read_data=0; set memRead=1 -> read_data=5 combinationally.

Source files
------------

// File: rtl/data_mem.sv
// Word-addressed 16-bit data memory for the MIPS MEM stage: combinational read, synchronous write.
// Optional macro DATA_MEM_READ_GATE_EN forces read_data to zero while memRead is low.
module data_mem #(
  parameter int unsigned        DEPTH      = 256,
  parameter logic [15:0]        INIT_WORD0 = 16'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [15:0] address,
  input  logic [15:0] write_data,
  output logic [15:0] read_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] index;
  logic          in_range;
  logic          write_en;
  logic [15:0]   word_rd;

  assign index = address[AW-1:0];

  // Any set bit above the index field addresses a word that does not exist.
  generate
    if (AW < 16) begin : g_range_check
      assign in_range = ~|address[15:AW];
    end else begin : g_full_range
      assign in_range = 1'b1;
    end
  endgenerate

  assign write_en = memWrite && in_range;

  // NOTE: every word is reset here because the datapath relies on defined
  // contents after reset; this keeps the array in flops rather than RAM macros.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      mem_q[0] <= INIT_WORD0;
    end else if (write_en) begin
      mem_q[index] <= write_data;
    end
  end

  // NOTE: default assignment first so the combinational read can never infer a latch.
  always_comb begin
    word_rd = '0;
    if (in_range) begin
      word_rd = mem_q[index];
    end
  end

`ifdef DATA_MEM_READ_GATE_EN
  assign read_data = memRead ? word_rd : 16'h0000;
`else
  // memRead has no effect in the ungated build.
  logic unused_mem_read;
  assign unused_mem_read = memRead;
  assign read_data       = word_rd;
`endif

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem; expected values are hand-computed.
// Follows DATA_MEM_READ_GATE_EN so the same bench covers both builds.
module tb_data_mem;

  logic        clk;
  logic        rst;
  logic        memRead;
  logic        memWrite;
  logic [15:0] address;
  logic [15:0] write_data;
  logic [15:0] read_data;

  int vectors;
  int miscompares;

  data_mem #(.DEPTH(256), .INIT_WORD0(16'd5)) dut (
    .clk        (clk),
    .rst        (rst),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    address = addr;
    #1;
    check(tag, read_data, exp);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst        = 1'b1;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    address    = 16'd0;
    write_data = 16'd0;
    tick();
    rst = 1'b0;

    // Reset contents; memRead low only matters in the gated build.
`ifdef DATA_MEM_READ_GATE_EN
    rd("rst_w0_noread", 16'd0, 16'd0);
`else
    rd("rst_w0_noread", 16'd0, 16'd5);
`endif
    memRead = 1'b1;
    rd("rst_w0", 16'd0, 16'd5);
    rd("rst_w1", 16'd1, 16'd0);
    rd("rst_w255", 16'd255, 16'd0);

    // Simultaneous read/write: old value before the edge, new after.
    address = 16'd20; write_data = 16'd15; memWrite = 1'b1;
    rd("rw_old", 16'd20, 16'd0);
    tick();
    memWrite = 1'b0;
    rd("rw_new", 16'd20, 16'd15);
    rd("neighbor21", 16'd21, 16'd0);

    // Data without strobe never lands.
    address = 16'd30; write_data = 16'hBEEF;
    repeat (3) tick();
    rd("no_strobe", 16'd30, 16'd0);

    // Out-of-range writes leave every word, including aliased indices, untouched.
    address = 16'h0114; write_data = 16'd7; memWrite = 1'b1;
    tick();
    address = 16'h0100; write_data = 16'd9;
    tick();
    memWrite = 1'b0;
    rd("oor_read", 16'h0114, 16'd0);
    rd("oor_alias20", 16'd20, 16'd15);
    rd("oor_alias0", 16'd0, 16'd5);
    rd("oor_topbit", 16'h8000, 16'd0);

    // Highest in-range word and its out-of-range alias.
    address = 16'd255; write_data = 16'hA5A5; memWrite = 1'b1;
    tick();
    memWrite = 1'b0;
    rd("top_word", 16'd255, 16'hA5A5);
    rd("top_alias", 16'h01FF, 16'd0);

    // Back-to-back writes: last wins.
    address = 16'd40; write_data = 16'd1; memWrite = 1'b1;
    tick();
    write_data = 16'd2;
    tick();
    memWrite = 1'b0;
    rd("b2b_last", 16'd40, 16'd2);

    // Reset beats a concurrent write and wipes earlier stores.
    rst = 1'b1; memWrite = 1'b1; address = 16'd0; write_data = 16'd9;
    tick();
    rst = 1'b0; memWrite = 1'b0;
    rd("rstprio_w0", 16'd0, 16'd5);
    rd("rstmid_w20", 16'd20, 16'd0);
    rd("rstmid_w255", 16'd255, 16'd0);
    rd("rstmid_w40", 16'd40, 16'd0);

    // Read gating (or its absence) at word 0.
    memRead = 1'b0;
`ifdef DATA_MEM_READ_GATE_EN
    rd("gate_off", 16'd0, 16'd0);
`else
    rd("gate_off", 16'd0, 16'd5);
`endif
    memRead = 1'b1;
    rd("gate_on", 16'd0, 16'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
